// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: one decimal digit per clock, least-significant digit first.
// Result valid DIGITS cycles after accept; held in DONE until out_ready, then one idle cycle.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 3,
  parameter int CNT_W  = $clog2(DIGITS+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err,
  output logic                busy
);

  localparam int W = 4*DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [W-1:0]     a_q, b_q, sum_q;
  logic             carry_q, cout_q, err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]       a_dig, b_dig, digit;
  logic [4:0]       raw;
  logic             carry_d, bad_d;
  logic [W-1:0]     sum_d;

  always_comb begin
    a_dig   = a_q[3:0];
    b_dig   = b_q[3:0];
    raw     = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_q};
    carry_d = 1'b0;
    digit   = raw[3:0];
    if (raw > 5'd9) begin
      // Only the low nibble of raw+6 is kept, so a 4-bit add gives the same digit.
      digit   = raw[3:0] + 4'd6;
      carry_d = 1'b1;
    end
    bad_d = (a_dig > 4'd9) || (b_dig > 4'd9);
    sum_d = W'({digit, sum_q} >> 4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= carry_d;
          err_q   <= err_q | bad_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIGITS-1)) begin
            cout_q  <= carry_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomized bench for bcd_serial_add_ctrl against a decimal-arithmetic reference.
module tb_bcd_serial_add_ctrl;

  localparam int D   = 3;
  localparam int W   = 4*D;
  localparam int POW = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] x);
    int v = 0;
    for (int i = D-1; i >= 0; i--) v = v*10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Expected {cout, sum} from plain decimal addition.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int v = bcd2int(x) + bcd2int(y) + int'(c);
    return {(v >= POW), int2bcd(v % POW)};
  endfunction

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input bit chk_val, input logic exp_err, input int stall);
    int n;
    logic [W:0] e;
    e = model(xa, xb, xc);
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_drop", {31'd0, in_ready}, 32'd0);
    chk("busy_run", {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, D);
    if (chk_val) begin
      chk("sum", {20'd0, sum}, {20'd0, e[W-1:0]});
      chk("cout", {31'd0, cout}, {31'd0, e[W]});
    end
    chk("err", {31'd0, err}, {31'd0, exp_err});
    for (int s = 0; s < stall; s++) begin
      a = rand_bcd(); b = rand_bcd(); cin = 1'b1; in_valid = (s % 2 == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_sum", {20'd0, sum}, {20'd0, e[W-1:0]});
      chk("stall_cout", {31'd0, cout}, {31'd0, e[W]});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct packed { logic [W:0] res; } exp_t;
  exp_t q[$];

  initial begin
    int cyc, last_acc, done_cnt;
    bit acc, ohs;
    logic [W:0] e;
    exp_t ex;

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {20'd0, sum}, 32'd0);
    chk("rst_cout_err", {30'd0, cout, err}, 32'd0);

    run_op(12'h999, 12'h001, 1'b0, 1'b1, 1'b0, 0);
    chk("t1_sum", {20'd0, sum}, 32'h000);
    chk("t1_cout", {31'd0, cout}, 32'd1);
    run_op(12'h456, 12'h123, 1'b1, 1'b1, 1'b0, 0);
    chk("t2_sum", {20'd0, sum}, 32'h580);
    run_op(12'h500, 12'h500, 1'b0, 1'b1, 1'b0, 0);
    chk("t3_cout", {31'd0, cout}, 32'd1);
    run_op(12'h1A3, 12'h001, 1'b0, 1'b0, 1'b1, 0);
    run_op(12'h001, 12'h001, 1'b0, 1'b1, 1'b0, 0);
    chk("t5_sum", {20'd0, sum}, 32'h002);
    run_op(12'h378, 12'h845, 1'b0, 1'b1, 1'b0, 5);

    // Asynchronous reset in the middle of RUN.
    a = 12'h777; b = 12'h777; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_sum", {20'd0, sum}, 32'd0);
    chk("mrst_cout_err", {30'd0, cout, err}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    run_op(12'h250, 12'h250, 1'b0, 1'b1, 1'b0, 0);
    chk("t6_sum", {20'd0, sum}, 32'h500);

    for (int i = 0; i < 20; i++) run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b1, 1'b0, i % 3);

    // Back-to-back streaming with both handshakes held high.
    out_ready = 1'b1;
    a = rand_bcd(); b = rand_bcd(); cin = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    cyc = 0; last_acc = -1; done_cnt = 0;
    while (done_cnt < 1000 && cyc < 6000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      ohs = out_valid && out_ready;
      if (ohs) begin
        if (q.size() == 0) begin
          chk("b2b_unexpected", 32'd1, 32'd0);
        end else begin
          ex = q.pop_front();
          chk("b2b_sum", {20'd0, sum}, {20'd0, ex.res[W-1:0]});
          chk("b2b_cout", {31'd0, cout}, {31'd0, ex.res[W]});
          chk("b2b_err", {31'd0, err}, 32'd0);
        end
        done_cnt++;
      end
      if (acc) begin
        e = model(a, b, cin);
        q.push_back('{res: e});
        if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, D+2);
        last_acc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        a = rand_bcd(); b = rand_bcd(); cin = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", done_cnt, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
